pic_inta_sequencer: RTL

Host-side interrupt acknowledge sequencer. It sits directly downstream of the PIC_8259 INT output and replaces the processor's bus logic. It synchronises INT and generates the two-pulse INTA handshake on its own. It captures the vector byte the PIC drives during the second pulse and hands that byte to the CPU core over a valid/ready interface. Optionally it also issues the non-specific EOI command write (OCW2) back to the PIC.

---
 rtl/pic_host_pkg.sv | 18 +
 rtl/pic_int_sync.sv | 18 +
 rtl/pic_inta_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pic_host_pkg.sv
// Shared types and constants for the host-side PIC interrupt acknowledge logic.
package pic_host_pkg;

  localparam int         CNT_W       = 8;
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    P1_LO,
    GAP1,
    P2_LO,
    VEC_HOLD,
    EOI_SETUP,
    EOI_WR,
    EOI_HOLD
  } state_t;

endpackage

// File: rtl/pic_int_sync.sv
// Two-flop synchroniser bringing the asynchronous PIC INT line into the clk domain.
module pic_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[0], d_i};
  end

  assign q_o = sync_reg[1];

endmodule

// File: rtl/pic_inta_sequencer.sv
// Generates the two-pulse INTA handshake, captures the PIC vector and hands it to the CPU.
// Optional non-specific EOI write path is built when PIC_HOST_EOI_EN is defined.
module pic_inta_sequencer
  import pic_host_pkg::*;
#(
  parameter int PULSE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_i,
  input  logic [7:0] d_i,
  output logic       inta_n_o,
  output logic [7:0] vec_o,
  output logic       vec_valid_o,
  input  logic       vec_ready_i,
  output logic       busy_o,
  input  logic       eoi_req_i,
  output logic       eoi_done_o,
  output logic       cs_n_o,
  output logic       wr_n_o,
  output logic       a0_o,
  output logic [7:0] d_o,
  output logic       d_oe_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       vec_reg;
  logic             int_s;
  logic             cnt_zero;
  logic             eoi_go;

  pic_int_sync u_int_sync (
    .clk (clk),
    .rst (rst),
    .d_i (int_i),
    .q_o (int_s)
  );

  assign cnt_zero = (cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      vec_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == P2_LO && cnt_zero) vec_reg <= d_i;
    end
  end

  // A completed handshake dispatches exactly like IDLE, so back-to-back
  // acknowledges are spaced by a single VEC_HOLD cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, VEC_HOLD: begin
        if (state_reg == IDLE || vec_ready_i) begin
          state_next = IDLE;
          if (eoi_go) begin
            state_next = EOI_SETUP;
          end else if (int_s) begin
            state_next = P1_LO;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      P1_LO, GAP1, P2_LO: begin
        if (cnt_zero) begin
          cnt_next = CNT_LOAD;
          if (state_reg == P1_LO)     state_next = GAP1;
          else if (state_reg == GAP1) state_next = P2_LO;
          else                        state_next = VEC_HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`ifdef PIC_HOST_EOI_EN
      EOI_SETUP: begin
        state_next = EOI_WR;
        cnt_next   = CNT_LOAD;
      end
      EOI_WR: begin
        if (cnt_zero) state_next = EOI_HOLD;
        else          cnt_next   = cnt_reg - 1'b1;
      end
      EOI_HOLD: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign inta_n_o    = !(state_reg == P1_LO || state_reg == P2_LO);
  assign vec_valid_o = (state_reg == VEC_HOLD);
  assign busy_o      = (state_reg != IDLE);
  assign vec_o       = vec_reg;

`ifdef PIC_HOST_EOI_EN
  logic eoi_pend_reg, eoi_pend_next;
  logic eoi_phase;

  // A request arriving while one is already pending collapses into it.
  assign eoi_pend_next = (state_next == EOI_SETUP && state_reg != EOI_SETUP) ?
                         1'b0 : (eoi_pend_reg | eoi_req_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) eoi_pend_reg <= 1'b0;
    else     eoi_pend_reg <= eoi_pend_next;
  end

  assign eoi_go     = eoi_pend_reg;
  assign eoi_phase  = (state_reg == EOI_SETUP) || (state_reg == EOI_WR) ||
                      (state_reg == EOI_HOLD);
  assign cs_n_o     = !eoi_phase;
  assign a0_o       = !eoi_phase;
  assign d_oe_o     = eoi_phase;
  assign d_o        = eoi_phase ? OCW2_NS_EOI : 8'h00;
  assign wr_n_o     = (state_reg != EOI_WR);
  assign eoi_done_o = (state_reg == EOI_HOLD);
`else
  logic eoi_req_unused;

  assign eoi_req_unused = eoi_req_i;
  assign eoi_go         = 1'b0;
  assign cs_n_o         = 1'b1;
  assign a0_o           = 1'b1;
  assign d_oe_o         = 1'b0;
  assign d_o            = 8'h00;
  assign wr_n_o         = 1'b1;
  assign eoi_done_o     = 1'b0;
`endif

endmodule
